param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WL, default 8, data word width in bits (1 to 64).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of storage entries (2 to 1024, power of two not required).
REQ-003 The block SHALL have parameter AF_LVL, default DEPTH-1, Count threshold at or above which AlmostFull asserts.
REQ-004 The block SHALL have parameter AE_LVL, default 1, Count threshold at or below which AlmostEmpty asserts.
REQ-005 The block SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have these ports:
  CLK  in  1  single clock, rising edge
  RST  in  1  reset, asynchronous, active-low
  wReq  in  1  write request
  din  in  WL  write data
  rReq  in  1  read request
  clrErr  in  1  clears sticky Overflow/Underflow
  dout  out  WL  read data
  Full  out  1  Count == DEPTH
  Empty  out  1  Count == 0
  AlmostFull  out  1  Count >= AF_LVL
  AlmostEmpty  out  1  Count <= AE_LVL
  Count  out  clog2(DEPTH+1)  current occupancy
  Overflow  out  1  sticky, a write was rejected
  Underflow  out  1  sticky, a read was rejected
  Error  out  1  combinational, (wReq & !wAcc) | (rReq & !rAcc) this cycle

Function
REQ-007 Storage SHALL be a DEPTH-entry array with read and write pointers that wrap from DEPTH-1 to 0; memory contents SHALL NOT be reset.
REQ-008 A read SHALL be accepted (rAcc) when rReq=1 and Empty=0.
REQ-009 A write SHALL be accepted (wAcc) when wReq=1 and (Full=0 or rAcc=1); when Full, a simultaneous read and write SHALL both be accepted with Count unchanged.
REQ-010 When Empty, a simultaneous read and write SHALL accept only the write; Count becomes 1 and Underflow sets.
REQ-011 Count SHALL update on the clock edge: +1 on wAcc only, -1 on rAcc only, unchanged on both or neither.
REQ-012 Full, Empty, AlmostFull and AlmostEmpty SHALL be decoded from the registered Count with no further latency.
REQ-013 FWFT=0: on rAcc, dout SHALL load the head entry at that clock edge (one-cycle latency) and SHALL hold its value otherwise.
REQ-014 FWFT=1: dout SHALL present the head entry combinationally whenever Empty=0; rAcc advances to the next entry; when Empty=1, dout SHALL hold the last value presented.
REQ-015 FWFT=1: a word written into an empty FIFO SHALL appear on dout the cycle after the write edge.
REQ-016 Overflow SHALL set on any rejected write, and Underflow on any rejected read; both SHALL hold until clrErr=1 or reset.
REQ-017 If clrErr and a new error event occur in the same cycle, the flag SHALL remain set.
REQ-018 Error SHALL be purely combinational and SHALL NOT affect FIFO state.
REQ-019 Parameter violations (AF_LVL > DEPTH, AE_LVL >= AF_LVL) SHALL be flagged by an elaboration-time check.

Reset
REQ-020 When RST=0, asynchronously and without waiting for a clock edge, the block SHALL drive: pointers 0, Count 0, Empty 1, Full 0, AlmostEmpty 1, AlmostFull 0, Overflow 0, Underflow 0, and dout 0.
REQ-021 A reset asserted mid-transfer SHALL discard all stored words; the first read after release SHALL return only data written after release.
REQ-022 A request present on the first edge after reset release SHALL be processed normally.

Verification (WL=8, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-023 Write 0x11,0x22,0x33,0x44, then read 4 words, FWFT=0 -> dout is 0x11..0x44, each one cycle after its rReq; Count steps 1,2,3,4,3,2,1,0; Full is high only at Count 4.
REQ-024 With Full, write 0x55 alone -> write rejected, Error=1 for that cycle, Overflow=1 and stays 1 until clrErr pulses; Count stays 4.
REQ-025 With Full, assert rReq and wReq (0x55) together -> dout=0x11, Count stays 4, no error; subsequent reads return 0x22,0x33,0x44,0x55.
REQ-026 With Empty, assert rReq and wReq (0x66) together -> Underflow=1, Count=1; FWFT=1 -> dout=0x66 on the next cycle.
REQ-027 Run 10 write/read pairs so the pointers wrap twice -> data stays in order; AlmostFull asserts at Count 3 and AlmostEmpty at Count 1 or less.
REQ-028 Assert RST between clock edges with Count=3 -> all outputs reach reset values immediately; after release, write 0x77 then read -> 0x77 is returned.

Source files
------------

// File: rtl/param_fifo.sv
// ---------------------------------------------------------------------------
// param_fifo -- single-clock parameterised synchronous FIFO
//
// Stores up to DEPTH words of WL bits in a circular buffer. Supports a
// registered read mode (FWFT=0, dout loads on an accepted read) and a
// first-word-fall-through mode (FWFT=1, head word shown combinationally).
// When the FIFO is full, a simultaneous read and write is accepted with
// Count unchanged. When it is empty, only the write of such a pair is
// accepted and the read is flagged as an underflow.
//
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-low reset
//   wReq / din  write request and write data
//   rReq        read request
//   clrErr      clears the sticky Overflow/Underflow flags
//   dout        read data
//   Full        Count == DEPTH
//   Empty       Count == 0
//   AlmostFull  Count >= AF_LVL
//   AlmostEmpty Count <= AE_LVL
//   Count       current occupancy
//   Overflow    sticky, a write was rejected
//   Underflow   sticky, a read was rejected
//   Error       combinational, a request is being rejected this cycle
// ---------------------------------------------------------------------------
module param_fifo #(
  parameter int WL     = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int FWFT   = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         wReq,
  input  logic [WL-1:0]                din,
  input  logic                         rReq,
  input  logic                         clrErr,
  output logic [WL-1:0]                dout,
  output logic                         Full,
  output logic                         Empty,
  output logic                         AlmostFull,
  output logic                         AlmostEmpty,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow,
  output logic                         Underflow,
  output logic                         Error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = CW'(1'b1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  // Reject illegal configurations at elaboration time.
  if (WL < 1 || WL > 64) begin : g_bad_wl
    $error("param_fifo: WL must be in 1..64");
  end
  if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $error("param_fifo: DEPTH must be in 2..1024");
  end
  if (AF_LVL > DEPTH || AE_LVL >= AF_LVL) begin : g_bad_levels
    $error("param_fifo: need AF_LVL <= DEPTH and AE_LVL < AF_LVL");
  end

  // Circular-buffer pointer advance; DEPTH need not be a power of two,
  // so the wrap is an explicit compare rather than natural overflow.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == LAST_PTR) begin
      nxt = {PW{1'b0}};
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  logic [WL-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic          unf_r;
  logic [WL-1:0] dout_r;

  logic          empty_s;
  logic          full_s;
  logic          r_acc_s;
  logic          w_acc_s;
  logic [WL-1:0] head_s;

  assign empty_s = (count_r == ZERO_C);
  assign full_s  = (count_r == DEPTH_C);
  assign head_s  = mem_r[rd_ptr_r];

  // Acceptance: a read needs data; a write needs space unless a read is
  // freeing a slot on the same edge.
  always_comb begin
    r_acc_s = 1'b0;
    w_acc_s = 1'b0;
    if (rReq && !empty_s) begin
      r_acc_s = 1'b1;
    end else begin
      r_acc_s = 1'b0;
    end
    if (wReq && (!full_s || r_acc_s)) begin
      w_acc_s = 1'b1;
    end else begin
      w_acc_s = 1'b0;
    end
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (w_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_C;
    end else begin
      if (w_acc_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (r_acc_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({w_acc_s, r_acc_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Read-data register: captures the head word on every accepted read.
  // In FWFT mode it doubles as the "last value presented" while empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout_r <= {WL{1'b0}};
    end else if (r_acc_s) begin
      dout_r <= head_s;
    end
  end

  // Sticky error flags; a new event in the clearing cycle wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= (wReq & ~w_acc_s) | (ovf_r & ~clrErr);
      unf_r <= (rReq & ~r_acc_s) | (unf_r & ~clrErr);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = empty_s ? dout_r : head_s;
  end else begin : g_reg
    assign dout = dout_r;
  end

  assign Full        = full_s;
  assign Empty       = empty_s;
  assign AlmostFull  = (count_r >= AF_C);
  assign AlmostEmpty = (count_r <= AE_C);
  assign Count       = count_r;
  assign Overflow    = ovf_r;
  assign Underflow   = unf_r;
  assign Error       = (wReq & ~w_acc_s) | (rReq & ~r_acc_s);

endmodule

// File: tb/tb_param_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_fifo -- self-checking bench for param_fifo (WL=8, DEPTH=4,
// AF_LVL=3, AE_LVL=1). One registered-read and one FWFT instance share the
// same stimulus and are compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_param_fifo;

  localparam int DEP = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wReq;
  logic [7:0] din;
  logic       rReq;
  logic       clrErr;

  logic [7:0] dout0, dout1;
  logic       full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic [2:0] cnt0, cnt1;
  logic       ovf0, ovf1, unf0, unf1, err0, err1;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] q[$];
  logic       ovf_m;
  logic       unf_m;
  logic [7:0] d0_m;      // expected registered-read dout
  logic [7:0] last1_m;   // last word presented by FWFT instance

  always #5 CLK = ~CLK;

  param_fifo #(.WL(8), .DEPTH(DEP), .AF_LVL(3), .AE_LVL(1), .FWFT(0)) u_reg (
    .CLK(CLK), .RST(RST), .wReq(wReq), .din(din), .rReq(rReq), .clrErr(clrErr),
    .dout(dout0), .Full(full0), .Empty(empty0), .AlmostFull(af0),
    .AlmostEmpty(ae0), .Count(cnt0), .Overflow(ovf0), .Underflow(unf0),
    .Error(err0)
  );

  param_fifo #(.WL(8), .DEPTH(DEP), .AF_LVL(3), .AE_LVL(1), .FWFT(1)) u_fwft (
    .CLK(CLK), .RST(RST), .wReq(wReq), .din(din), .rReq(rReq), .clrErr(clrErr),
    .dout(dout1), .Full(full1), .Empty(empty1), .AlmostFull(af1),
    .AlmostEmpty(ae1), .Count(cnt1), .Overflow(ovf1), .Underflow(unf1),
    .Error(err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] head1();
    return (q.size() > 0) ? q[0] : last1_m;
  endfunction

  task automatic check_state(input string where);
    int n;
    n = q.size();
    check({where, ":count0"}, 64'(cnt0),   64'(n));
    check({where, ":count1"}, 64'(cnt1),   64'(n));
    check({where, ":full0"},  64'(full0),  64'(n == DEP));
    check({where, ":full1"},  64'(full1),  64'(n == DEP));
    check({where, ":empty0"}, 64'(empty0), 64'(n == 0));
    check({where, ":empty1"}, 64'(empty1), 64'(n == 0));
    check({where, ":af0"},    64'(af0),    64'(n >= 3));
    check({where, ":af1"},    64'(af1),    64'(n >= 3));
    check({where, ":ae0"},    64'(ae0),    64'(n <= 1));
    check({where, ":ae1"},    64'(ae1),    64'(n <= 1));
    check({where, ":ovf0"},   64'(ovf0),   64'(ovf_m));
    check({where, ":ovf1"},   64'(ovf1),   64'(ovf_m));
    check({where, ":unf0"},   64'(unf0),   64'(unf_m));
    check({where, ":unf1"},   64'(unf1),   64'(unf_m));
    check({where, ":dout0"},  64'(dout0),  64'(d0_m));
    check({where, ":dout1"},  64'(dout1),  64'(head1()));
  endtask

  // One clock cycle of stimulus; called and returns at a falling edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic racc, wacc;
    wReq = w; din = d; rReq = r; clrErr = c;
    #1;
    racc = r && (q.size() > 0);
    wacc = w && ((q.size() < DEP) || racc);
    check("err0",      64'(err0),  64'((w && !wacc) || (r && !racc)));
    check("err1",      64'(err1),  64'((w && !wacc) || (r && !racc)));
    check("dout0_pre", 64'(dout0), 64'(d0_m));
    check("dout1_pre", 64'(dout1), 64'(head1()));
    @(posedge CLK);
    if (racc) begin
      d0_m    = q.pop_front();
      last1_m = d0_m;
    end
    if (wacc) q.push_back(d);
    ovf_m = (w && !wacc) || (ovf_m && !c);
    unf_m = (r && !racc) || (unf_m && !c);
    @(negedge CLK);
    wReq = 1'b0; rReq = 1'b0; clrErr = 1'b0;
    check_state("cyc");
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0; unf_m = 1'b0; d0_m = 8'h00; last1_m = 8'h00;
  endtask

  initial begin
    wReq = 1'b0; rReq = 1'b0; clrErr = 1'b0; din = 8'h00;
    model_reset();
    RST = 1'b1;
    #2 RST = 1'b0;
    @(negedge CLK);
    check_state("reset");
    RST = 1'b1;

    // basic ordering; first write lands on the first edge after release
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // overflow when full, sticky until clrErr, clear loses to new event
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h56, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // simultaneous read+write while full
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous read+write while empty
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // threshold walk up and down
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // pointer wrap: ten write/read pairs
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(i * 13 + 1), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0));
    end

    // asynchronous reset mid-transfer with three words stored
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge CLK);
    check_state("rst_held");
    RST = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_read", 64'(dout0), 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
